// File: rtl/sign_mag_pkg.sv
// sign_mag_pkg: shared conversion-mode and elastic-buffer state types
package sign_mag_pkg;
  typedef enum logic {MODE_TC2SM = 1'b0, MODE_SM2TC = 1'b1} conv_mode_e;
  typedef enum logic [1:0] {BUF_EMPTY = 2'd0, BUF_ONE = 2'd1, BUF_FULL = 2'd2} buf_state_e;
endpackage

// File: rtl/sign_mag_lane.sv
// sign_mag_lane: combinational per-element two's-complement <-> sign-magnitude conversion (elem,mode -> result,sat)
module sign_mag_lane
  import sign_mag_pkg::*;
#(
  parameter int ELEM_W = 8
) (
  input  logic [ELEM_W-1:0] elem,
  input  conv_mode_e        mode,
  output logic [ELEM_W-1:0] result,
  output logic              sat
);
  logic [ELEM_W-1:0] neg;
  logic [ELEM_W-1:0] mag_neg;
  logic              is_min;
  assign is_min  = elem == {1'b1, {(ELEM_W-1){1'b0}}};
  assign neg     = -elem;
  assign mag_neg = -{1'b0, elem[ELEM_W-2:0]};
  assign sat     = is_min;
  always_comb
    result = !elem[ELEM_W-1] ? elem :
             is_min ? (mode == MODE_TC2SM ? {ELEM_W{1'b1}} : {ELEM_W{1'b0}}) :
             mode == MODE_TC2SM ? {1'b1, neg[ELEM_W-2:0]} : mag_neg;
endmodule

// File: rtl/sign_mag_stream_converter.sv
// sign_mag_stream_converter: valid/ready lane-parallel sign-magnitude converter with 2-entry skid buffer and saturating sat-lane counter
module sign_mag_stream_converter
  import sign_mag_pkg::*;
#(
  parameter int LANES  = 4,
  parameter int ELEM_W = 8,
  parameter int CNT_W  = 16
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    in_valid_i,
  output logic                    in_ready_o,
  input  logic [LANES*ELEM_W-1:0] in_data_i,
  input  logic                    in_mode_i,
  output logic                    out_valid_o,
  input  logic                    out_ready_i,
  output logic [LANES*ELEM_W-1:0] out_data_o,
  output logic [LANES-1:0]        out_sat_o,
  output logic [CNT_W-1:0]        sat_cnt_o,
  input  logic                    sat_cnt_clr_i
);
  localparam int DW = LANES * ELEM_W;
  localparam int PW = $clog2(LANES + 1);
  logic [DW-1:0]    conv_data, main_data, skid_data;
  logic [LANES-1:0] conv_sat, main_sat, skid_sat;
  buf_state_e       state, state_n;
  logic             in_ready_q, out_valid_q;
  logic             in_hs, out_hs;
  logic             load_conv, load_skid, load_from_skid;
  logic [PW-1:0]    pop;
  logic [CNT_W:0]   sum;
  logic [CNT_W-1:0] cnt, cnt_n;
  for (genvar i = 0; i < LANES; i++) begin : g_lane
    sign_mag_lane #(.ELEM_W(ELEM_W)) u_lane (
      .elem   (in_data_i[i*ELEM_W +: ELEM_W]),
      .mode   (conv_mode_e'(in_mode_i)),
      .result (conv_data[i*ELEM_W +: ELEM_W]),
      .sat    (conv_sat[i])
    );
  end
  assign in_ready_o  = in_ready_q;
  assign out_valid_o = out_valid_q;
  assign out_data_o  = main_data;
  assign out_sat_o   = main_sat;
  assign sat_cnt_o   = cnt;
  assign in_hs       = in_valid_i && in_ready_q;
  assign out_hs      = out_valid_q && out_ready_i;
  always_comb begin
    state_n        = state;
    load_conv      = 1'b0;
    load_skid      = 1'b0;
    load_from_skid = 1'b0;
    case (state)
      BUF_EMPTY: if (in_hs) begin
        state_n   = BUF_ONE;
        load_conv = 1'b1;
      end
      BUF_ONE: if (in_hs && !out_hs) begin
        state_n   = BUF_FULL;
        load_skid = 1'b1;
      end else if (in_hs) begin
        load_conv = 1'b1;
      end else if (out_hs) begin
        state_n = BUF_EMPTY;
      end
      BUF_FULL: if (out_hs) begin
        state_n        = BUF_ONE;
        load_from_skid = 1'b1;
      end
      default: state_n = BUF_EMPTY;
    endcase
  end
  always_comb begin
    pop = '0;
    for (int k = 0; k < LANES; k++) pop = pop + PW'(main_sat[k]);
  end
  assign sum = {1'b0, cnt} + (CNT_W+1)'(pop);
  always_comb
    cnt_n = out_hs ? (sat_cnt_clr_i ? CNT_W'(pop) : (sum[CNT_W] ? {CNT_W{1'b1}} : sum[CNT_W-1:0])) :
            (sat_cnt_clr_i ? '0 : cnt);
  // ready/valid are registered from the next state so neither depends combinationally on out_ready_i
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      state       <= BUF_EMPTY;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      main_data   <= '0;
      main_sat    <= '0;
      skid_data   <= '0;
      skid_sat    <= '0;
      cnt         <= '0;
    end else begin
      state       <= state_n;
      in_ready_q  <= state_n != BUF_FULL;
      out_valid_q <= state_n != BUF_EMPTY;
      cnt         <= cnt_n;
      if (load_conv) begin
        main_data <= conv_data;
        main_sat  <= conv_sat;
      end else if (load_from_skid) begin
        main_data <= skid_data;
        main_sat  <= skid_sat;
      end
      if (load_skid) begin
        skid_data <= conv_data;
        skid_sat  <= conv_sat;
      end
    end
endmodule

// File: doc/sign_mag_stream_converter.md
SIGN_MAG_STREAM_CONVERTER -- requirements
Module: sign_mag_stream_converter

Interface
REQ-001 SHALL have parameter LANES, default 4, number of packed elements per beat (1..16).
REQ-002 SHALL have parameter ELEM_W, default 8, element width in bits (4..16).
REQ-003 SHALL have parameter CNT_W, default 16, width of the saturation event counter.
REQ-004 SHALL have clk_i, input, 1, the single clock.
REQ-005 SHALL have rst_ni, input, 1, reset, asynchronous and active-low.
REQ-006 SHALL have in_valid_i, input, 1, the input beat is valid.
REQ-007 SHALL have in_ready_o, output, 1, the block accepts an input beat.
REQ-008 SHALL have in_data_i, input, LANES*ELEM_W, packed elements; lane i occupies bits [i*ELEM_W +: ELEM_W].
REQ-009 SHALL have in_mode_i, input, 1, per-beat mode sampled with the beat: 0 = TC2SM, 1 = SM2TC.
REQ-010 SHALL have out_valid_o, output, 1, the output beat is valid.
REQ-011 SHALL have out_ready_i, input, 1, the downstream accepts the output beat.
REQ-012 SHALL have out_data_o, output, LANES*ELEM_W, converted elements with the same lane packing.
REQ-013 SHALL have out_sat_o, output, LANES, per-lane flag set when that lane saturated or normalised.
REQ-014 SHALL have sat_cnt_o, output, CNT_W, running count of saturated lanes.
REQ-015 SHALL have sat_cnt_clr_i, input, 1, synchronous clear of sat_cnt_o.

Function
REQ-016 TC2SM SHALL map a non-negative element x to x, and a negative element x to {1, |x|}.
REQ-017 TC2SM SHALL map the most negative value (1 followed by zeros) to all-ones (-(2^(ELEM_W-1)-1)) and SHALL set the lane's out_sat_o bit.
REQ-018 SM2TC SHALL map {0,m} to m and {1,m} to -m in two's complement.
REQ-019 SM2TC SHALL map negative zero (1 followed by zeros) to 0 and SHALL set the lane's out_sat_o bit.
REQ-020 Lanes SHALL convert independently; only the beat's sampled mode applies to all lanes of that beat.
REQ-021 The block SHALL use a 2-entry elastic buffer (main register plus skid register), giving a latency of 1 cycle from input handshake to out_valid_o.
REQ-022 in_ready_o SHALL be driven directly from a register, with no combinational path from out_ready_i.
REQ-023 With out_ready_i held high, the block SHALL sustain one beat per cycle.
REQ-024 A beat SHALL transfer only when valid and ready are both high on the same edge; beats SHALL NOT be dropped or duplicated, and order SHALL be preserved.
REQ-025 While out_valid_o is high and out_ready_i is low, out_data_o and out_sat_o SHALL hold stable.
REQ-026 Buffer state: EMPTY, ONE, FULL.
REQ-027 EMPTY -> ONE on an input handshake.
REQ-028 ONE stays in ONE on a simultaneous input and output handshake.
REQ-029 ONE -> FULL on an input handshake without an output handshake.
REQ-030 ONE -> EMPTY on an output handshake without an input handshake.
REQ-031 FULL -> ONE on an output handshake, with the skid entry moving to the output register.
REQ-032 in_ready_o SHALL be low only in FULL.
REQ-033 sat_cnt_o SHALL increase by popcount(out_sat_o) on each output handshake.
REQ-034 sat_cnt_o SHALL saturate at 2^CNT_W-1 and SHALL NOT wrap.
REQ-035 When sat_cnt_clr_i coincides with an output handshake, sat_cnt_o SHALL load popcount(out_sat_o) of that beat; clear does not discard the coincident beat.

Reset
REQ-036 On rst_ni low, out_valid_o SHALL be 0, in_ready_o SHALL be 1 once reset releases, out_data_o SHALL be 0, out_sat_o SHALL be 0, sat_cnt_o SHALL be 0, and the buffer state SHALL be EMPTY.
REQ-037 Reset mid-transfer SHALL discard all buffered beats; no partial beat SHALL appear after reset.

Structure
REQ-038 A shared package sign_mag_pkg SHALL hold the conv_mode_e enum (MODE_TC2SM=0, MODE_SM2TC=1) and the buffer-state enum.
REQ-039 Per-element conversion SHALL be a combinational sub-module sign_mag_lane, parameterised by ELEM_W, with ports elem, mode, result and sat, and instantiated LANES times.
REQ-040 Conversion SHALL occur before the elastic buffer, so that the buffer stores converted data and sat flags.

Verification
REQ-041 LANES=4, ELEM_W=8, TC2SM, in_data_i=0x80_FF_7F_00, out_ready_i=1 -> next cycle out_data_o=0xFF_81_7F_00, out_sat_o=4'b1000, sat_cnt_o=1 after the handshake.
REQ-042 SM2TC, in_data_i=0x80_81_FF_05 -> out_data_o=0x00_FF_81_05, out_sat_o=4'b1000.
REQ-043 Hold out_ready_i=0 and present 3 beats -> 2 accepted, in_ready_o=0 after the second; release -> the beats emerge in order with data stable while stalled.
REQ-044 Present a random valid/ready stream of 1000 beats with alternating mode -> scoreboard matches, with no loss or duplication.
REQ-045 With CNT_W=4, send 20 beats each containing one 0x80 lane in TC2SM -> sat_cnt_o sticks at 15; sat_cnt_clr_i coincident with a saturating beat -> 1.
REQ-046 Assert rst_ni low with the buffer FULL -> out_valid_o=0 and sat_cnt_o=0 immediately; after release the first output equals the first post-reset input.
